// File: rtl/cache_pkg.sv
// cache_pkg: shared constants and types for the direct-mapped read cache
// controller.
//   LINE_W                    : width of one cache line / memory block in bits.
//   INDEX_LSB / INDEX_MSB     : line index field of a byte address.
//   TAG_LSB                   : lowest bit of the tag field.
//   WORD_SEL_MSB/WORD_SEL_LSB : 32-bit word select within a line.
//   state_t                   : controller FSM states.
package cache_pkg;

  localparam int LINE_W       = 512;
  localparam int INDEX_LSB    = 6;
  localparam int INDEX_MSB    = 10;
  localparam int TAG_LSB      = 11;
  localparam int WORD_SEL_MSB = 5;
  localparam int WORD_SEL_LSB = 2;
  localparam int INDEX_W      = INDEX_MSB - INDEX_LSB + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FILL   = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/cache_tag_array.sv
// cache_tag_array: tag store for the direct-mapped cache.
//   clk, reset : clock; asynchronous active-high reset clears every valid bit.
//   idx        : line index used for both the read and the write port.
//   rd_tag     : stored tag of line idx (combinational read).
//   rd_valid   : valid bit of line idx (combinational read).
//   wr_en      : write strobe; stores wr_tag into line idx and marks it valid.
//   wr_tag     : tag to store.
module cache_tag_array
  import cache_pkg::*;
#(
  parameter int NLINES = 32,
  parameter int TAG_W  = 21
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] idx,
  output logic [TAG_W-1:0]   rd_tag,
  output logic               rd_valid,
  input  logic               wr_en,
  input  logic [TAG_W-1:0]   wr_tag
);

  logic [TAG_W-1:0]  tags [NLINES];
  logic [NLINES-1:0] valid;

  // Only the valid bits need clearing; tag contents are don't-care while invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[idx] <= wr_tag;
    end
  end

  assign rd_tag   = tags[idx];
  assign rd_valid = valid[idx];

endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, read-only cache controller (one request at a time).
//   clk, reset        : clock (rising edge); asynchronous active-high reset.
//   cpu_req/cpu_addr  : read request, sampled only while idle.
//   cpu_ready         : one-cycle pulse; cpu_rdata is valid in that cycle.
//   cpu_rdata         : registered read data.
//   busy              : high whenever the controller is not idle.
//   mem_req/mem_addr  : block fetch, held until mem_ready.
//   mem_ready         : one-cycle acknowledge, mem_rdata valid the same cycle.
//   mem_rdata         : fetched block, word 0 in the top 32 bits.
//   write_cache       : line fill strobe to the external data array.
//   cache_addr        : latched request address driving the data array.
//   cache_data_in     : fill data (mem_rdata passed through).
//   ishit             : data array line valid bit for cache_addr.
//   cache_data_out    : data array word selected by cache_addr[5:2].
//   hit_cnt/miss_cnt  : saturating statistics counters.
//   fsm_state         : current FSM state, for observation.
//
// Handshakes: the CPU side has no back-pressure -- cpu_req is taken only in
// IDLE and ignored otherwise, and cpu_ready is a single-cycle pulse with no
// acknowledge. On the memory side mem_req is a level held with a stable
// mem_addr until a single-cycle mem_ready; mem_ready outside FILL is ignored.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int NLINES = 32,
  parameter int TAG_W  = 21
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [31:0]       cpu_addr,
  output logic              cpu_ready,
  output logic [31:0]       cpu_rdata,
  output logic              busy,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              write_cache,
  output logic [31:0]       cache_addr,
  output logic [LINE_W-1:0] cache_data_in,
  input  logic              ishit,
  input  logic [31:0]       cache_data_out,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
  output state_t            fsm_state
);

  state_t             state_q, state_d;
  logic [31:0]        addr_q;
  logic               refill_q;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [TAG_W-1:0]   stored_tag;
  logic               stored_valid;
  logic               hit;

  assign idx = addr_q[INDEX_MSB:INDEX_LSB];
  assign tag = addr_q[TAG_LSB +: TAG_W];
  assign hit = ishit & stored_valid & (stored_tag == tag);

  cache_tag_array #(
    .NLINES (NLINES),
    .TAG_W  (TAG_W)
  ) u_tags (
    .clk      (clk),
    .reset    (reset),
    .idx      (idx),
    .rd_tag   (stored_tag),
    .rd_valid (stored_valid),
    .wr_en    (write_cache),
    .wr_tag   (tag)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cpu_ready   = 1'b0;
    busy        = 1'b1;
    mem_req     = 1'b0;
    write_cache = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (cpu_req) state_d = LOOKUP;
      end
      LOOKUP: begin
        state_d = hit ? RESP : FILL;
      end
      FILL: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          write_cache = 1'b1;
          state_d     = LOOKUP;
        end
      end
      RESP: begin
        cpu_ready = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // refill_q marks the LOOKUP that re-checks a just-filled line, so that a
  // miss is counted once as a miss and not a second time as a hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      cpu_rdata <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      refill_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && cpu_req) addr_q <= cpu_addr;
      if (write_cache) refill_q <= 1'b1;
      if (state_q == LOOKUP) begin
        refill_q <= 1'b0;
        if (hit) begin
          cpu_rdata <= cache_data_out;
          if (!refill_q && hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
        end else if (miss_cnt != 32'hFFFF_FFFF) begin
          miss_cnt <= miss_cnt + 32'd1;
        end
      end
    end
  end

  assign mem_addr      = {addr_q[31:INDEX_LSB], {INDEX_LSB{1'b0}}};
  assign cache_addr    = addr_q;
  assign cache_data_in = mem_rdata;
  assign fsm_state     = state_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: self-checking bench for cache_ctrl. The bench plays the CPU,
// the memory and the external data array; a behavioural cache map predicts
// hit/miss and counters, and a monitor checks read data from a queue.
module tb_cache_ctrl;
  import cache_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req;
  logic [31:0]       cpu_addr;
  logic              cpu_ready;
  logic [31:0]       cpu_rdata;
  logic              busy;
  logic              mem_req;
  logic [31:0]       mem_addr;
  logic              mem_ready;
  logic [LINE_W-1:0] mem_rdata;
  logic              write_cache;
  logic [31:0]       cache_addr;
  logic [LINE_W-1:0] cache_data_in;
  logic              ishit;
  logic [31:0]       cache_data_out;
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;
  state_t            fsm_state;

  cache_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_req        (cpu_req),
    .cpu_addr       (cpu_addr),
    .cpu_ready      (cpu_ready),
    .cpu_rdata      (cpu_rdata),
    .busy           (busy),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata),
    .write_cache    (write_cache),
    .cache_addr     (cache_addr),
    .cache_data_in  (cache_data_in),
    .ishit          (ishit),
    .cache_data_out (cache_data_out),
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt),
    .fsm_state      (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  function automatic void check32(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endfunction

  function automatic void note_fail(input string name);
    n_checks++;
    $display("FAIL %s: expected event did not occur", name);
  endfunction

  // ---------------- memory contents and data array ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) + 32'h1234_5678;
  endfunction

  function automatic logic [LINE_W-1:0] blk_data(input logic [31:0] blk);
    logic [LINE_W-1:0] d;
    d = '0;
    for (int w = 0; w < 16; w++) d[LINE_W-1-32*w -: 32] = mem_word(blk + 32'(4 * w));
    return d;
  endfunction

  logic [LINE_W-1:0] d_line [32];
  logic [31:0]       d_valid = '0;

  always @(posedge clk) begin
    if (write_cache) begin
      d_line[cache_addr[10:6]]  <= cache_data_in;
      d_valid[cache_addr[10:6]] <= 1'b1;
    end
  end

  always_comb begin
    int w;
    w              = int'(cache_addr[5:2]);
    ishit          = d_valid[cache_addr[10:6]];
    cache_data_out = d_line[cache_addr[10:6]][LINE_W-1-32*w -: 32];
  end

  // ---------------- reference model: which block each line holds ----------------
  logic [20:0] m_tag   [32];
  logic        m_valid [32];
  logic [31:0] m_hits;
  logic [31:0] m_misses;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
    end
    m_hits   = '0;
    m_misses = '0;
  endfunction

  function automatic logic model_access(input logic [31:0] a);
    int   line;
    logic h;
    line = int'(a[10:6]);
    h    = m_valid[line] && (m_tag[line] == a[31:11]);
    if (h) begin
      if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 1;
    end else begin
      if (m_misses != 32'hFFFF_FFFF) m_misses = m_misses + 1;
      m_valid[line] = 1'b1;
      m_tag[line]   = a[31:11];
    end
    return h;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    if (cpu_ready) begin
      if (exp_q.size() == 0) begin
        note_fail("unexpected_cpu_ready");
      end else begin
        e = exp_q.pop_front();
        check32("cpu_rdata", cpu_rdata, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issues one read from a cycle start with the DUT idle, acts as memory for
  // any fill, and returns at the start of the cycle after cpu_ready.
  task automatic do_read(input logic [31:0] addr);
    logic        exp_hit;
    logic [31:0] blk;
    int          n, ready_at, wait_left, fills;
    bit          done, serve;
    exp_hit = model_access(addr);
    blk     = {addr[31:6], 6'b0};
    exp_q.push_back(mem_word(addr));
    cpu_req  = 1'b1;
    cpu_addr = addr;
    @(negedge clk);
    check32("accept_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    cpu_req   = 1'b0;
    cpu_addr  = $urandom;
    n         = 1;
    ready_at  = -100;
    wait_left = $urandom_range(0, 3);
    fills     = 0;
    done      = 0;
    serve     = 0;
    while (!done && n < 64) begin
      @(negedge clk);
      check32("cache_addr", cache_addr, addr);
      if (write_cache) fills++;
      if (cpu_ready) begin
        done = 1;
        check32("latency", 32'(n), exp_hit ? 32'd2 : 32'(ready_at + 2));
      end else if (mem_req && !mem_ready) begin
        check32("mem_addr", mem_addr, blk);
        if (wait_left == 0) serve = 1;
        else wait_left--;
      end
      @(posedge clk); #1;
      n++;
      mem_ready = 1'b0;
      if (serve) begin
        mem_ready = 1'b1;
        mem_rdata = blk_data(blk);
        ready_at  = n;
        serve     = 0;
      end
    end
    mem_ready = 1'b0;
    if (!done) note_fail("read_timeout");
    check32("fill_count", 32'(fills), exp_hit ? 32'd0 : 32'd1);
    check32("hit_cnt", hit_cnt, m_hits);
    check32("miss_cnt", miss_cnt, m_misses);
  endtask

  // cpu_req held high for 30 cycles on a cached address, with random stray
  // mem_ready: one request per IDLE visit gives exactly 10 hits, no fills.
  task automatic hold_req_run(input logic [31:0] addr);
    int  readies, wcs, mreqs;
    logic h;
    readies = 0;
    wcs     = 0;
    mreqs   = 0;
    for (int k = 0; k < 10; k++) begin
      h = model_access(addr);
      exp_q.push_back(mem_word(addr));
    end
    cpu_req  = 1'b1;
    cpu_addr = addr;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (cpu_ready) readies++;
      if (write_cache) wcs++;
      if (mem_req) mreqs++;
      @(posedge clk); #1;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = blk_data($urandom & 32'hFFFF_FFC0);
    end
    cpu_req   = 1'b0;
    mem_ready = 1'b0;
    check32("hold_ready_count", 32'(readies), 32'd10);
    check32("hold_write_cache", 32'(wcs), 32'd0);
    check32("hold_mem_req", 32'(mreqs), 32'd0);
    check32("hold_hit_cnt", hit_cnt, m_hits);
    check32("hold_miss_cnt", miss_cnt, m_misses);
  endtask

  // Asserts reset while a fill is outstanding, then sends the late mem_ready.
  task automatic reset_mid_fill(input logic [31:0] addr);
    int n;
    bit seen;
    cpu_req  = 1'b1;
    cpu_addr = addr;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    n    = 0;
    seen = 0;
    while (!seen && n < 8) begin
      @(negedge clk);
      if (mem_req) seen = 1;
      else begin
        @(posedge clk); #1;
      end
      n++;
    end
    if (!seen) note_fail("reach_fill");
    reset = 1'b1;
    #1;
    check32("rst_mem_req", 32'(mem_req), 32'd0);
    check32("rst_busy", 32'(busy), 32'd0);
    check32("rst_state", 32'(fsm_state), 32'(IDLE));
    check32("rst_hit_cnt", hit_cnt, 32'd0);
    check32("rst_miss_cnt", miss_cnt, 32'd0);
    check32("rst_cpu_rdata", cpu_rdata, 32'd0);
    check32("rst_cache_addr", cache_addr, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    mem_ready = 1'b1;
    mem_rdata = blk_data({addr[31:6], 6'b0});
    @(negedge clk);
    check32("late_ready_write_cache", 32'(write_cache), 32'd0);
    check32("late_ready_mem_req", 32'(mem_req), 32'd0);
    check32("late_ready_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    mem_ready = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a;
    reset     = 1'b1;
    cpu_req   = 1'b0;
    cpu_addr  = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("init_state", 32'(fsm_state), 32'(IDLE));
    check32("init_busy", 32'(busy), 32'd0);
    check32("init_cpu_ready", 32'(cpu_ready), 32'd0);
    check32("init_mem_req", 32'(mem_req), 32'd0);
    check32("init_write_cache", 32'(write_cache), 32'd0);
    check32("init_cpu_rdata", cpu_rdata, 32'd0);
    check32("init_hit_cnt", hit_cnt, 32'd0);
    check32("init_miss_cnt", miss_cnt, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed: first miss, same-line hit, conflicting tag on index 1.
    do_read(32'h0000_0040);
    check32("first_miss_cnt", miss_cnt, 32'd1);
    do_read(32'h0000_0048);
    check32("first_hit_cnt", hit_cnt, 32'd1);
    do_read(32'h0000_0840);
    do_read(32'h0000_0040);
    check32("conflict_miss_cnt", miss_cnt, 32'd3);

    // Random reads over a small set of tags and indices to force conflicts.
    for (int i = 0; i < 40; i++) begin
      a = {21'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 2'b00};
      do_read(a);
    end

    // Continuous cpu_req with stray mem_ready.
    do_read(32'h0000_0104);
    hold_req_run(32'h0000_0104);

    // Reset in the middle of a fill; the same address must miss afterwards.
    reset_mid_fill(32'h0010_0000);
    do_read(32'h0010_0000);
    check32("post_reset_miss_cnt", miss_cnt, 32'd1);
    do_read(32'h0000_0040);

    // Hit counter saturation.
    force dut.hit_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.hit_cnt;
    @(posedge clk); #1;
    m_hits = 32'hFFFF_FFFF;
    do_read(32'h0000_0044);
    check32("hit_cnt_saturated", hit_cnt, 32'hFFFF_FFFF);

    repeat (3) @(posedge clk);
    check32("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
